// File: rtl/note_spawner_pkg.sv
// Shared types and constants for the note spawner: FSM states, buffered note entry, gap width.
// Pure declarations; no latency or backpressure of its own.
package note_spawner_pkg;

    localparam int GAP_W      = 9;
    localparam int LANE_W_MAX = 3;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        WAIT,
        PUSH
    } state_t;

    // Lane field sized for the widest lane count; narrower configs zero-extend.
    typedef struct packed {
        logic [LANE_W_MAX-1:0] lane;
        logic [31:0]           ts;
    } note_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous first-word-fall-through FIFO; written entry is visible one cycle after push.
// Push into a full FIFO is accepted only when a pop happens in the same cycle; pop on empty is ignored.
module note_fifo
    import note_spawner_pkg::*;
#(
    parameter  int W     = 35,
    parameter  int DEPTH = 8,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/note_spawner.sv
// Spawns time-stamped notes on random lanes after random gaps (period gap+2); note visible one cycle after PUSH.
// Renderer backpressure via note_valid/note_ready; a PUSH into a full, non-popping FIFO drops the note and sets sticky overflow. Optional SPAWN_NO_REPEAT_EN.
module note_spawner
    import note_spawner_pkg::*;
#(
    parameter  int LANES      = 4,
    parameter  int MIN_GAP    = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int LANE_W     = clog2(LANES),
    localparam int CNT_W      = clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       ranNum,
    input  logic [31:0]       timeElapsed,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [LANE_W-1:0] note_lane,
    output logic [31:0]       note_time,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [LANE_W-1:0]  lane_raw;
    logic [LANE_W-1:0]  lane_sel;
    logic               overflow_q, overflow_d;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    note_t              wr_note;
    note_t              head_note;
    logic               unused_ran_bits;

    assign unused_ran_bits = ^ranNum[31:16];

    assign lane_raw = LANE_W'(int'(ranNum[15:8]) % LANES);

`ifdef SPAWN_NO_REPEAT_EN
    logic [LANE_W-1:0] prev_lane_q;

    // Tracks every attempted push, dropped ones included, so the lane pattern ignores backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_lane_q <= '0;
        end else if (push) begin
            prev_lane_q <= lane_q;
        end
    end

    assign lane_sel = (lane_raw == prev_lane_q) ? LANE_W'((int'(lane_raw) + 1) % LANES)
                                                : lane_raw;
`else
    assign lane_sel = lane_raw;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        lane_d  = lane_q;
        push    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            gap_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SAMPLE;
                end
                SAMPLE: begin
                    lane_d  = lane_sel;
                    gap_d   = GAP_W'(MIN_GAP) + GAP_W'(ranNum[7:0]);
                    state_d = WAIT;
                end
                WAIT: begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q <= GAP_W'(1)) begin
                        state_d = PUSH;
                    end
                end
                PUSH: begin
                    push    = 1'b1;
                    state_d = SAMPLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            lane_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            lane_q     <= lane_d;
            overflow_q <= overflow_d;
        end
    end

    assign pop        = note_valid && note_ready;
    assign overflow_d = overflow_q | (push && fifo_full && !pop);

    always_comb begin
        wr_note      = '0;
        wr_note.lane = LANE_W_MAX'(lane_q);
        wr_note.ts   = timeElapsed;
    end

    note_fifo #(
        .W     ($bits(note_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (wr_note),
        .dout_o  (head_note),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Head fields are masked while empty so the outputs read zero after reset.
    assign note_valid = !fifo_empty;
    assign note_lane  = note_valid ? LANE_W'(head_note.lane) : '0;
    assign note_time  = note_valid ? head_note.ts : '0;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_note_spawner.sv
// Scoreboard bench for note_spawner: expected notes queued at predicted PUSH cycles, checked on pop.
module tb_note_spawner;
    import note_spawner_pkg::*;

    localparam int LANES   = 4;
    localparam int MIN_GAP = 16;
    localparam int DEPTH   = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] ranNum;
    logic [31:0] timeElapsed;
    logic        note_valid;
    logic        note_ready;
    logic [1:0]  note_lane;
    logic [31:0] note_time;
    logic [3:0]  fifo_count;
    logic        overflow;

    typedef struct {
        int          lane;
        logic [31:0] ts;
    } exp_t;

    exp_t exp_q[$];
    int   lane_log[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   next_push = -1;
    int   gap_m     = 0;
    int   prev_m    = 0;
    int   mcount    = 0;
    int   spawns    = 0;
    bit   exp_ovf   = 1'b0;

    note_spawner #(
        .LANES      (LANES),
        .MIN_GAP    (MIN_GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .ranNum      (ranNum),
        .timeElapsed (timeElapsed),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_lane   (note_lane),
        .note_time   (note_time),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] tval(input int c);
        return 32'hA000_0000 + 32'(c) * 32'd5;
    endfunction

    function automatic int model_lane();
        int l;
        l = int'(ranNum[15:8]) % LANES;
`ifdef SPAWN_NO_REPEAT_EN
        if (l == prev_m) l = (l + 1) % LANES;
`endif
        return l;
    endfunction

    // One clock: settle the model for this cycle, take the edge, then check state after it.
    task automatic step();
        bit   pop_m;
        bit   push_m;
        exp_t e;
        int   l;
        pop_m  = (mcount != 0) && note_ready && !reset;
        push_m = enable && !reset && (cyc == next_push);
        if (reset) begin
            exp_q.delete();
            exp_ovf   = 1'b0;
            prev_m    = 0;
            next_push = -1;
        end else begin
            if (pop_m) begin
                e = exp_q.pop_front();
                checks++;
                if (note_lane !== 2'(e.lane) || note_time !== e.ts) begin
                    errors++;
                    $display("FAIL pop_data cyc=%0d got lane=%0d time=%h exp lane=%0d time=%h",
                             cyc, note_lane, note_time, e.lane, e.ts);
                end
                lane_log.push_back(int'(note_lane));
            end
            if (push_m) begin
                l      = model_lane();
                prev_m = l;
                spawns++;
                if (exp_q.size() < DEPTH || pop_m) begin
                    e.lane = l;
                    e.ts   = timeElapsed;
                    exp_q.push_back(e);
                end else begin
                    exp_ovf = 1'b1;
                end
                next_push += gap_m + 2;
            end
        end
        mcount = exp_q.size();
        @(posedge clock);
        #1;
        cyc++;
        timeElapsed = tval(cyc);
        checks++;
        if (fifo_count !== 4'(mcount)) begin
            errors++;
            $display("FAIL fifo_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, mcount);
        end
        checks++;
        if (note_valid !== (mcount != 0)) begin
            errors++;
            $display("FAIL note_valid cyc=%0d got=%b exp=%b", cyc, note_valid, mcount != 0);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, exp_ovf);
        end
    endtask

    task automatic start_spawn(input logic [31:0] v);
        ranNum    = v;
        enable    = 1'b1;
        gap_m     = MIN_GAP + int'(v[7:0]);
        next_push = cyc + 2 + gap_m;
    endtask

    task automatic stop_and_drain(input string name);
        enable     = 1'b0;
        next_push  = -1;
        note_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        step();
        checks++;
        if (exp_q.size() != 0 || note_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain left=%0d valid=%b exp left=0 valid=0", name, exp_q.size(), note_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (note_valid !== 1'b0 || note_lane !== 2'd0 || note_time !== 32'd0 ||
            fifo_count !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b l=%0d t=%h c=%0d o=%b exp all zero",
                     note_valid, note_lane, note_time, fifo_count, overflow);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.gap_q !== 9'd0 || dut.lane_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_internal got state=%0d gap=%0d lane=%0d exp 0 0 0",
                     dut.state_q, dut.gap_q, dut.lane_q);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_first_spawn();
        int t0;
        note_ready = 1'b0;
        start_spawn(32'h0000_0305);
        t0 = cyc;
        for (int i = 0; i < 23; i++) step();
        checks++;
        if (dut.state_q !== PUSH || note_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_push_cycle got state=%0d valid=%b exp state=%0d valid=0",
                     dut.state_q, note_valid, PUSH);
        end
        step();
        checks++;
        if (note_valid !== 1'b1 || note_lane !== 2'd3 || note_time !== tval(t0 + 23)) begin
            errors++;
            $display("FAIL first_note got v=%b lane=%0d time=%h exp v=1 lane=3 time=%h",
                     note_valid, note_lane, note_time, tval(t0 + 23));
        end
        stop_and_drain("first");
    endtask

    task automatic test_enable_drop();
        note_ready = 1'b0;
        start_spawn(32'h0000_0102);
        for (int i = 0; i < 200 && exp_q.size() < 2; i++) step();
        for (int i = 0; i < 100 && cyc != next_push - 5; i++) step();
        checks++;
        if (dut.state_q !== WAIT) begin
            errors++;
            $display("FAIL drop_in_wait got state=%0d exp=%0d", dut.state_q, WAIT);
        end
        enable    = 1'b0;
        next_push = -1;
        step();
        checks++;
        if (dut.state_q !== IDLE || dut.gap_q !== 9'd0) begin
            errors++;
            $display("FAIL drop_to_idle got state=%0d gap=%0d exp state=%0d gap=0",
                     dut.state_q, dut.gap_q, IDLE);
        end
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (fifo_count !== 4'd2) begin
            errors++;
            $display("FAIL drop_no_push got count=%0d exp=2", fifo_count);
        end
        stop_and_drain("drop");
    endtask

    task automatic test_overflow();
        lane_log.delete();
        spawns     = 0;
        note_ready = 1'b0;
        start_spawn(32'h0000_0100);
        for (int i = 0; i < 300 && spawns < 9; i++) step();
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sat got count=%0d ovf=%b exp count=8 ovf=1", fifo_count, overflow);
        end
        stop_and_drain("overflow");
        checks++;
        if (lane_log.size() != 8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drained got notes=%0d ovf=%b exp notes=8 ovf=1", lane_log.size(), overflow);
        end
    endtask

    task automatic test_reset_mid();
        note_ready = 1'b0;
        start_spawn(32'h0000_0100);
        for (int i = 0; i < 200 && exp_q.size() < 3; i++) step();
        enable = 1'b0;
        reset  = 1'b1;
        step();
        checks++;
        if (fifo_count !== 4'd0 || note_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got count=%0d valid=%b ovf=%b exp 0 0 0", fifo_count, note_valid, overflow);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_full_push_pop();
        spawns     = 0;
        note_ready = 1'b0;
        start_spawn(32'h0000_0100);
        for (int i = 0; i < 300 && spawns < 8; i++) step();
        for (int i = 0; i < 40 && cyc != next_push; i++) step();
        note_ready = 1'b1;
        step();
        note_ready = 1'b0;
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop got count=%0d ovf=%b exp count=8 ovf=0", fifo_count, overflow);
        end
        stop_and_drain("fullpp");
    endtask

    task automatic test_no_repeat();
        int exp_lanes[4];
`ifdef SPAWN_NO_REPEAT_EN
        exp_lanes = '{2, 3, 2, 3};
`else
        exp_lanes = '{2, 2, 2, 2};
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        lane_log.delete();
        spawns     = 0;
        note_ready = 1'b1;
        start_spawn(32'h0000_0200);
        for (int i = 0; i < 200 && spawns < 4; i++) step();
        stop_and_drain("norepeat");
        checks++;
        if (lane_log.size() != 4) begin
            errors++;
            $display("FAIL lane_seq_len got=%0d exp=4", lane_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lane_log[i] != exp_lanes[i]) begin
                    errors++;
                    $display("FAIL lane_seq[%0d] got=%0d exp=%0d", i, lane_log[i], exp_lanes[i]);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        note_ready  = 1'b0;
        ranNum      = 32'd0;
        timeElapsed = tval(0);
        test_reset();
        test_first_spawn();
        test_enable_drop();
        test_overflow();
        test_reset_mid();
        test_full_push_pop();
        test_no_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
